// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the bit-serial ALU controller.
//   ALUOP_*  : 4-bit alu_op codes {AInvert, BInvert, Operation[1:0]}
//   OP_*     : 2-bit Operation field that selects the slice output
//   state_t  : controller FSM states
//   is_legal_op / is_arith_op : alu_op decode helpers
package cpu_pkg;

   localparam logic [3:0] ALUOP_AND = 4'b0000;
   localparam logic [3:0] ALUOP_OR  = 4'b0001;
   localparam logic [3:0] ALUOP_ADD = 4'b0010;
   localparam logic [3:0] ALUOP_SUB = 4'b0110;
   localparam logic [3:0] ALUOP_SLT = 4'b0111;
   localparam logic [3:0] ALUOP_NOR = 4'b1100;

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_SUM  = 2'b10;
   localparam logic [1:0] OP_LESS = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   function automatic logic is_legal_op(input logic [3:0] op);
      case (op)
         ALUOP_AND, ALUOP_OR, ALUOP_ADD,
         ALUOP_SUB, ALUOP_SLT, ALUOP_NOR: is_legal_op = 1'b1;
         default:                         is_legal_op = 1'b0;
      endcase
   endfunction

   // Ops whose flags come from the adder (overflow is only meaningful here).
   function automatic logic is_arith_op(input logic [3:0] op);
      is_arith_op = (op == ALUOP_ADD) || (op == ALUOP_SUB) || (op == ALUOP_SLT);
   endfunction

endpackage

// File: rtl/alu_slice_1bit.sv
// One-bit ALU slice: optional inversion of A/B, full adder, and a 4:1
// output mux (AND / OR / sum / less).
//   a, b         : operand bits
//   a_inv, b_inv : invert a / b before use
//   cin          : carry in
//   less         : value driven out for the LESS operation
//   op           : Operation field (OP_AND/OP_OR/OP_SUM/OP_LESS)
//   res          : selected output bit
//   cout, sum    : full-adder carry out and sum (always computed)
module alu_slice_1bit
   import cpu_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       a_inv,
   input  logic       b_inv,
   input  logic       cin,
   input  logic       less,
   input  logic [1:0] op,
   output logic       res,
   output logic       cout,
   output logic       sum
);

   logic aa, bb;

   assign aa   = a ^ a_inv;
   assign bb   = b ^ b_inv;
   assign sum  = aa ^ bb ^ cin;
   assign cout = (aa & bb) | (aa & cin) | (bb & cin);

   always_comb begin
      res = 1'b0;
      case (op)
         OP_AND:  res = aa & bb;
         OP_OR:   res = aa | bb;
         OP_SUM:  res = sum;
         OP_LESS: res = less;
         default: res = 1'b0;
      endcase
   end

endmodule

// File: rtl/bitserial_alu_ctrl.sv
// Bit-serial ALU controller: runs one alu_slice_1bit across a WIDTH-bit word,
// LSB first, one bit per clock, holding the ripple carry in a register and
// shifting result bits in from the MSB end.
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : request handshake (a, b, alu_op latched on accept)
//   out_valid / out_ready: result handshake
//   result, zero         : assembled result and result==0
//   carry_out, overflow  : adder carry out of MSB, signed overflow
//   op_err               : alu_op was not a legal code
module bitserial_alu_ctrl
   import cpu_pkg::*;
#(
   parameter int WIDTH = 24,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry_out,
   output logic             overflow,
   output logic             op_err
);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               carry;
   logic [WIDTH-1:0]   a_q, b_q, res_q;
   logic [3:0]         op_q;

   logic               s_res, s_cout, s_sum;
   logic               msb;
   logic [WIDTH-1:0]   res_shift;
   logic               ovf_raw;

   alu_slice_1bit u_slice (
      .a     (a_q[cnt]),
      .b     (b_q[cnt]),
      .a_inv (op_q[3]),
      .b_inv (op_q[2]),
      .cin   (carry),
      .less  (1'b0),
      .op    (op_q[1:0]),
      .res   (s_res),
      .cout  (s_cout),
      .sum   (s_sum)
   );

   assign msb       = (cnt == CNT_W'(WIDTH-1));
   assign res_shift = {s_res, res_q[WIDTH-1:1]};
   // carry register still holds the carry into the MSB on the MSB edge
   assign ovf_raw   = carry ^ s_cout;

   assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
   assign result    = res_q;
   assign zero      = (res_q == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         carry     <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         res_q     <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         op_err    <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_q   <= a;
                  b_q   <= b;
                  op_q  <= alu_op;
                  cnt   <= '0;
                  carry <= alu_op[2];
                  state <= S_RUN;
               end
            end

            S_RUN: begin
               carry <= s_cout;
               cnt   <= cnt + 1'b1;
               if (!msb) begin
                  res_q <= res_shift;
               end else begin
                  state     <= S_DONE;
                  out_valid <= 1'b1;
                  if (!is_legal_op(op_q)) begin
                     res_q     <= '0;
                     carry_out <= 1'b0;
                     overflow  <= 1'b0;
                     op_err    <= 1'b1;
                  end else begin
                     carry_out <= s_cout;
                     overflow  <= is_arith_op(op_q) & ovf_raw;
                     op_err    <= 1'b0;
                     // SLT: sign of (a-b) corrected by overflow gives a<b
                     if (op_q[1:0] == OP_LESS)
                        res_q <= {{(WIDTH-1){1'b0}}, s_sum ^ ovf_raw};
                     else
                        res_q <= res_shift;
                  end
               end
            end

            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (in_valid) begin
                     a_q   <= a;
                     b_q   <= b;
                     op_q  <= alu_op;
                     cnt   <= '0;
                     carry <= alu_op[2];
                     state <= S_RUN;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bitserial_alu_ctrl.sv
// Self-checking bench for bitserial_alu_ctrl: directed cases plus random
// operations compared against an arithmetic reference model.
module tb_bitserial_alu_ctrl;

   localparam int WIDTH = 24;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic [3:0]       alu_op = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] result;
   logic             zero, carry_out, overflow, op_err;

   int n_chk = 0;
   int n_err = 0;

   logic [WIDTH-1:0] exp_r;
   logic             exp_co, exp_ov, exp_err;

   bitserial_alu_ctrl #(.WIDTH(WIDTH), .CNT_W(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .alu_op    (alu_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .carry_out (carry_out),
      .overflow  (overflow),
      .op_err    (op_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain word arithmetic on the (optionally inverted) operands.
   task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                        input logic [3:0] mop);
      logic [WIDTH-1:0] aa, bb;
      logic [WIDTH:0]   s;
      logic             cin;
      int               sa;
      bit               legal, arith;
      legal = (mop == 4'b0000) || (mop == 4'b0001) || (mop == 4'b0010) ||
              (mop == 4'b0110) || (mop == 4'b0111) || (mop == 4'b1100);
      arith = (mop == 4'b0010) || (mop == 4'b0110) || (mop == 4'b0111);
      if (!legal) begin
         exp_r = '0; exp_co = 1'b0; exp_ov = 1'b0; exp_err = 1'b1;
         return;
      end
      aa  = mop[3] ? ~ma : ma;
      bb  = mop[2] ? ~mb : mb;
      cin = mop[2];
      s   = {1'b0, aa} + {1'b0, bb} + (WIDTH+1)'(cin);
      sa  = int'($signed(aa)) + int'($signed(bb)) + int'(cin);
      exp_co  = s[WIDTH];
      exp_ov  = arith && (sa > (2**(WIDTH-1) - 1) || sa < -(2**(WIDTH-1)));
      exp_err = 1'b0;
      case (mop[1:0])
         2'b00: exp_r = aa & bb;
         2'b01: exp_r = aa | bb;
         2'b10: exp_r = s[WIDTH-1:0];
         default: exp_r = ($signed(ma) < $signed(mb)) ? WIDTH'(1) : '0;
      endcase
   endtask

   // Present a request while in IDLE; returns #1 after the accepting edge
   // with operands scrambled so later input changes must be ignored.
   task automatic start(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic [3:0] top);
      a = ta; b = tb; alu_op = top; in_valid = 1'b1;
      model(ta, tb, top);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = WIDTH'($urandom); b = WIDTH'($urandom); alu_op = 4'($urandom);
   endtask

   task automatic wait_done(input string tag);
      int lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, " latency"}, lat, 24);
      chk({tag, " result"}, 32'(result), 32'(exp_r));
      chk({tag, " zero"}, 32'(zero), 32'(exp_r == '0));
      chk({tag, " carry_out"}, 32'(carry_out), 32'(exp_co));
      chk({tag, " overflow"}, 32'(overflow), 32'(exp_ov));
      chk({tag, " op_err"}, 32'(op_err), 32'(exp_err));
   endtask

   task automatic release_result(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
      chk({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
   endtask

   task automatic run_op(input string tag, input logic [WIDTH-1:0] ta,
                         input logic [WIDTH-1:0] tb, input logic [3:0] top);
      start(ta, tb, top);
      wait_done(tag);
      release_result(tag);
   endtask

   initial begin
      logic [3:0] legal_ops [6];
      logic [3:0] rop;
      legal_ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

      #12;
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset result", 32'(result), 32'd0);
      chk("reset flags", {29'd0, carry_out, overflow, op_err}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("reset in_ready", 32'(in_ready), 32'd1);

      run_op("add ovf", 24'h7FFFFF, 24'h000001, 4'b0010);
      chk("add ovf lit", 32'(exp_r), 32'h800000);
      run_op("sub eq", 24'h000005, 24'h000005, 4'b0110);
      run_op("slt neg", 24'hFFFFFF, 24'h000001, 4'b0111);
      run_op("slt ovf", 24'h7FFFFF, 24'h800000, 4'b0111);
      run_op("nor", 24'h00FF00, 24'h0F0F0F, 4'b1100);
      run_op("and", 24'h00FF00, 24'h0F0F0F, 4'b0000);
      run_op("or", 24'h00FF00, 24'h0F0F0F, 4'b0001);
      run_op("illegal", 24'h123456, 24'h654321, 4'b1010);

      // Backpressure, then back-to-back issue on the release edge
      start(24'h00ABCD, 24'h001234, 4'b0010);
      wait_done("bp first");
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         a = WIDTH'($urandom); b = WIDTH'($urandom); alu_op = 4'b0110;
         @(posedge clk); #1;
         chk("bp hold valid", 32'(out_valid), 32'd1);
         chk("bp hold result", 32'(result), 32'(exp_r));
         chk("bp hold flags", {29'd0, carry_out, overflow, op_err},
             {29'd0, exp_co, exp_ov, exp_err});
         chk("bp in_ready", 32'(in_ready), 32'd0);
      end
      a = 24'h000010; b = 24'h000020; alu_op = 4'b0110; in_valid = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("b2b in_ready", 32'(in_ready), 32'd1);
      model(24'h000010, 24'h000020, 4'b0110);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      chk("b2b out_valid drop", 32'(out_valid), 32'd0);
      wait_done("b2b second");
      release_result("b2b second");

      // Asynchronous reset in the middle of a run
      start(24'hFFFFFF, 24'hFFFFFF, 4'b0010);
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst out_valid", 32'(out_valid), 32'd0);
      chk("midrst result", 32'(result), 32'd0);
      chk("midrst flags", {29'd0, carry_out, overflow, op_err}, 32'd0);
      #3 rst_n = 1'b1;
      #1;
      chk("midrst in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      run_op("post rst add", 24'h000001, 24'h000001, 4'b0010);
      chk("post rst lit", 32'(exp_r), 32'h000002);

      // Random operations, mostly legal codes with some illegal ones
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) rop = 4'($urandom);
         else rop = legal_ops[$urandom_range(0, 5)];
         run_op("rand", WIDTH'($urandom), WIDTH'($urandom), rop);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/bitserial_alu_ctrl.md
Name: bitserial_alu_ctrl

Overview:
- Bit-serial ALU controller for the 24-bit CPU.
- Sequences a single 1-bit ALU slice (AND/OR/ADD-SUB/LESS mux with A/B invert) across all WIDTH bits of a word, LSB first, one bit per clock.
- Holds the ripple carry between cycles and reassembles the word.
- Exposes valid/ready handshakes toward the issue logic and the writeback stage.

Parameters:
- WIDTH, 24: operand/result width in bits.
- CNT_W, 5: bit-counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  controller can accept a request.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- alu_op  in  4  {AInvert, BInvert, Operation[1:0]}.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  assembled result.
- zero  out  1  result == 0.
- carry_out  out  1  carry out of the MSB slice.
- overflow  out  1  signed overflow.
- op_err  out  1  alu_op was not a legal code.

Behaviour:
- Legal alu_op codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
- Any other code: result=0, zero=1, carry_out=0, overflow=0, op_err=1. The request still runs the full WIDTH cycles.
- FSM states:
  - IDLE: in_ready=1.
  - RUN: in_ready=0.
  - DONE: out_valid=1.
- Accept: on an edge with IDLE && in_valid, latch a, b, alu_op, clear bit counter, set carry register = BInvert, go to RUN.
- in_ready = IDLE || (DONE && out_ready), combinational. This allows back-to-back issue.
- RUN, edge k (k=0..WIDTH-1): slice inputs are a[k]^AInvert and b[k]^BInvert with the current carry.
  - Slice output by Operation: 00 = AND, 01 = OR, 10 = sum, 11 = LESS. LESS is 0 for every bit position.
  - Result bit shifts into the result register from the MSB end.
  - Carry register updated with the slice carry.
  - Counter increments.
- MSB edge (k=WIDTH-1):
  - Record carry_in_msb.
  - carry_out = slice carry.
  - overflow = carry_in_msb ^ carry_out for ADD/SUB/SLT; 0 for AND/OR/NOR.
  - For SLT, after the final shift set result = {WIDTH-1 zeros, sum_msb ^ overflow}.
  - Go to DONE.
- Latency: out_valid rises exactly WIDTH edges after the accepting edge (24 for default).
- DONE:
  - result and all flags held stable while out_valid && !out_ready.
  - On out_ready: if in_valid is also high, accept the new request and go to RUN; otherwise go to IDLE.
  - out_valid drops on the same edge.
- zero: combinational from the held result; meaningful only while out_valid=1.
- Input changes on a/b/alu_op outside the accept edge have no effect.
- in_valid during RUN: ignored, not queued.
- Reset (any state, including mid-RUN):
  - state=IDLE, counter=0, carry=0, result=0, carry_out=0, overflow=0, op_err=0, out_valid=0.
  - in_ready=1 once rst_n deasserts.

Decomposition:
- Shared package (cpu_pkg), constants:
  - ALUOP_AND/OR/ADD/SUB/SLT/NOR.
  - Operation field encodings (OP_AND=2'b00, OP_OR=2'b01, OP_SUM=2'b10, OP_LESS=2'b11).
- Shared package, typedef: state enum {S_IDLE, S_RUN, S_DONE}.
- Sub-module alu_slice_1bit: combinational, ports (a, b, a_inv, b_inv, cin, less, op[1:0]) -> (res, cout, sum). Instantiated once.
- Controller holds the FSM, counter, carry register and result shift register.

Test Plan:
1. ADD a=0x7FFFFF, b=0x000001 -> result=0x800000, overflow=1, carry_out=0, zero=0, out_valid exactly 24 edges after accept.
2. SUB a=0x000005, b=0x000005 -> result=0x000000, zero=1, carry_out=1, overflow=0.
3. SLT a=0xFFFFFF, b=0x000001 -> result=0x000001. Then SLT a=0x7FFFFF, b=0x800000 (overflow case) -> result=0x000000.
4. NOR a=0x00FF00, b=0x0F0F0F -> 0xF000F0. AND same operands -> 0x000F00, overflow=0. Illegal op 1010 -> result=0, op_err=1.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE -> result/flags stable, in_ready=0, in_valid ignored. Then out_ready=1 with in_valid=1 in the same cycle -> next op accepted and its result 24 edges later.
6. Reset: assert rst_n=0 asynchronously at bit 10 of a RUN -> all outputs zero immediately. After release in_ready=1, and a fresh ADD 1+1 returns 0x000002.
